// File: rtl/bitop_stimulus_checker.sv
// Self-test front end for the 8-bit AND/OR bitwise unit.
// Generates operand pairs from an LFSR and drives them to the unit.
// Checks the unit's combinational result against a locally computed value.
// Folds each result into a rotate-XOR signature and counts mismatches.
module bitop_stimulus_checker #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [WIDTH-1:0] result_in,
  output logic             op_x,
  output logic             op_sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] lfsr_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [CNT_W-1:0] num_ops_reg;

  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] op_b_next;
  logic [WIDTH-1:0] lfsr_next;
  logic [CNT_W:0]   idx_inc;
  logic             last_op;

  // Next-value helpers. idx_inc is one bit wider than idx so that
  // num_ops = all-ones finishes instead of wrapping.
  always_comb begin
    expected  = op_x ? (op_a & op_b) : (op_a | op_b);
    op_b_next = {lfsr_reg[WIDTH/2-1:0], lfsr_reg[WIDTH-1:WIDTH/2]} ^ WIDTH'(8'h3C);
    lfsr_next = {lfsr_reg[WIDTH-2:0],
                 lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    idx_inc   = {1'b0, idx_reg} + {{CNT_W{1'b0}}, 1'b1};
    last_op   = (idx_inc == {1'b0, num_ops_reg});
  end

  // Run controller: issue an op, check it on the following cycle, repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lfsr_reg    <= '0;
      idx_reg     <= '0;
      num_ops_reg <= '0;
      op_x        <= 1'b0;
      op_sel      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signature   <= '0;
      err_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_ops_reg <= num_ops;
            lfsr_reg    <= SEED;
            idx_reg     <= '0;
            signature   <= '0;
            err_count   <= '0;
            busy        <= 1'b1;
            if (num_ops == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          op_a      <= lfsr_reg;
          op_b      <= op_b_next;
          op_x      <= idx_reg[0];
          op_sel    <= idx_reg[1];
          state_reg <= CHECK;
        end
        CHECK: begin
          if ((result_in != expected) && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          signature <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ result_in;
          lfsr_reg  <= lfsr_next;
          idx_reg   <= idx_inc[CNT_W-1:0];
          if (last_op) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= ISSUE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitop_stimulus_checker.sv
// Bench for bitop_stimulus_checker: models the bitwise unit (optionally faulty)
// and predicts each run's operands, signature and error count.
module tb_bitop_stimulus_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_ops = '0;
  logic [7:0] result_in;
  logic       op_x;
  logic       op_sel;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic [7:0] err_count;

  int unit_mode = 0;
  int n_checks  = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  bitop_stimulus_checker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .result_in (result_in),
    .op_x      (op_x),
    .op_sel    (op_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .err_count (err_count)
  );

  // Unit under self-test: 0 = correct, 1 = output stuck at zero,
  // 2 = bit 0 flipped on AND operations only.
  function automatic logic [7:0] unit_fn(input int mode, input logic x,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = x ? (a & b) : (a | b);
    if (mode == 1) r = 8'h00;
    else if (mode == 2 && x) r = r ^ 8'h01;
    return r;
  endfunction

  assign result_in = unit_fn(unit_mode, op_x, op_a, op_b);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete run; every cycle after start is accepted is checked.
  task automatic do_run(input int n, input int mode, input bit spam,
                        output logic [7:0] sig_out);
    logic [7:0] ea[$], eb[$];
    logic       ex[$];
    logic [7:0] l, a, b, want, got, sig;
    int         errs;
    l = 8'hA5; sig = 8'h00; errs = 0;
    for (int k = 0; k < n; k++) begin
      a = l;
      b = {l[3:0], l[7:4]} ^ 8'h3C;
      ea.push_back(a); eb.push_back(b); ex.push_back(k % 2 == 1);
      want = (k % 2 == 1) ? (a & b) : (a | b);
      got  = unit_fn(mode, (k % 2 == 1), a, b);
      if (got != want && errs < 255) errs++;
      sig = {sig[6:0], sig[7]} ^ got;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    unit_mode = mode;
    start   = 1'b1;
    num_ops = n[7:0];
    @(posedge clk); #1;
    for (int c = 1; c <= 2 * n + 2; c++) begin
      if (c % 2 == 0 && c <= 2 * n) begin
        check_val("op_a", op_a, ea[(c - 2) / 2]);
        check_val("op_b", op_b, eb[(c - 2) / 2]);
        check_val("op_x", op_x, ex[(c - 2) / 2]);
        check_val("op_sel", op_sel, ((c - 2) / 2 / 2) % 2);
      end
      check_val("done", done, (c == 2 * n + 1));
      check_val("busy", busy, (c <= 2 * n + 1));
      if (c >= 2 * n + 1) begin
        check_val("signature", signature, sig);
        check_val("err_count", err_count, errs);
      end
      if (c == 2 * n + 2) break;
      start = spam && (c < 2 * n + 1);
      if (spam) num_ops = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("run n=%0d mode=%0d spam=%0d sig=%02h err=%0d", n, mode, spam, signature, err_count);
    sig_out = sig;
  endtask

  initial begin
    logic [7:0] s, s_ref;
    int n, m;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sig", signature, 0);
    check_val("rst_err", err_count, 0);
    check_val("rst_op_a", op_a, 0);
    check_val("rst_op_x", op_x, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(0, 0, 0, s);
    check_val("zero_op_a", op_a, 0);
    check_val("zero_op_b", op_b, 0);
    check_val("zero_op_x", op_x, 0);

    do_run(1, 0, 0, s);
    check_val("n1_sig_const", signature, 8'hE7);
    check_val("n1_op_b_const", op_b, 8'h66);

    do_run(2, 0, 0, s);
    check_val("n2_sig_const", signature, 8'hC7);
    check_val("n2_op_a_const", op_a, 8'h4A);
    check_val("n2_op_b_const", op_b, 8'h98);
    check_val("n2_op_x_const", op_x, 1);

    do_run(2, 1, 0, s);
    check_val("stuck_err_const", err_count, 2);
    check_val("stuck_sig_const", signature, 8'h00);

    do_run(4, 0, 1, s);
    s_ref = signature;
    do_run(4, 0, 0, s);
    check_val("spam_vs_single", s_ref, signature);

    // Reset during CHECK of the second op of a 4-op run.
    start = 1'b1; num_ops = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_op_a", op_a, 8'h4A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_sig", signature, 0);
    check_val("mid_rst_err", err_count, 0);
    check_val("mid_rst_op_a", op_a, 0);
    check_val("mid_rst_op_b", op_b, 0);
    check_val("mid_rst_op_x", op_x, 0);
    check_val("mid_rst_op_sel", op_sel, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_val("post_rst_done", done, 0);
    end
    do_run(1, 0, 0, s);
    check_val("post_rst_sig", signature, 8'hE7);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 20);
      m = $urandom_range(0, 2);
      do_run(n, m, $urandom_range(0, 1) == 1, s);
    end
    do_run(255, 2, 0, s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitop_stimulus_checker.md
Name: bitop_stimulus_checker

Overview:
- Initiator and checker for the 8-bit AND/OR bitwise operation unit.
- Generates operand pairs from an LFSR and drives the op select (x), sel, a and b to the unit.
- Samples the unit's result one cycle later and compares it against an internally computed expected value.
- Accumulates a rotate-XOR signature and a mismatch count; used as the on-chip self-test front end for the bitwise datapath.

Parameters:
- WIDTH, 8, operand/result width (LFSR taps defined for 8 only).
- CNT_W, 8, width of num_ops and err_count.
- SEED, 8'hA5, LFSR value loaded at start (must be nonzero).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- num_ops  input  CNT_W  number of operations in the run; latched on start.
- result_in  input  WIDTH  result returned by the bitwise unit (combinational from op_* outputs).
- op_x  output  1  op select to unit: 1 = AND, 0 = OR.
- op_sel  output  1  auxiliary select to unit; carries op index bit 1.
- op_a  output  WIDTH  operand A.
- op_b  output  WIDTH  operand B.
- busy  output  1  high from the start-accept cycle until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- signature  output  WIDTH  running result signature; held after done until next start.
- err_count  output  CNT_W  mismatch count, saturating at all-ones.

Behaviour:
- Reset: FSM returns to IDLE and all outputs are 0.
  - This includes op_*, busy, done, signature and err_count.
  - Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, ISSUE, CHECK, DONE.
- IDLE:
  - On start, latch num_ops, load lfsr = SEED, clear idx, signature and err_count, and set busy.
  - If num_ops == 0, go to DONE; otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Register op_a = lfsr.
  - Register op_b = {lfsr[3:0], lfsr[7:4]} ^ 8'h3C.
  - Register op_x = idx[0] and op_sel = idx[1].
  - Go to CHECK.
- CHECK (1 cycle):
  - op_* are held stable. Expected value is op_x ? (op_a & op_b) : (op_a | op_b).
  - If result_in != expected, err_count += 1, saturating.
  - Update signature = {signature[6:0], signature[7]} ^ result_in.
  - Advance lfsr = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and increment idx.
  - If idx+1 == num_ops, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle):
  - done = 1; busy drops the next cycle; return to IDLE.
  - signature, err_count and op_* hold their values.
- Throughput: 2 cycles per op. A run of N ops gives its done pulse N*2+1 cycles after the start-accept cycle, counting the ISSUE/CHECK pairs plus DONE.
- start asserted while busy (ISSUE/CHECK/DONE) is ignored and has no queued effect.
- num_ops changes after the start-accept cycle have no effect.
- The first op is always OR (idx=0); ops then alternate OR/AND.
- The idx compare is full CNT_W width. num_ops = 2^CNT_W-1 completes without wrap.

Test Plan:
- Reset then start with num_ops=1 and a correct unit:
  - Response: op_a=A5, op_b=66, op_x=0; result E7; signature=E7; err_count=0.
  - done pulses exactly 3 cycles after start is accepted.
- num_ops=2, correct unit:
  - Second op: op_a=4A, op_b=98, op_x=1; result 08.
  - Final signature=C7, err_count=0.
- num_ops=2 with result_in forced to 00:
  - err_count=2, signature=00.
- num_ops=0:
  - done pulses in the cycle after the start-accept cycle; signature=00, err_count=00; op_* stay 0.
- start re-asserted every cycle during a 4-op run:
  - Exactly one done; results identical to a single-start run; next start after IDLE restarts from A5.
- rst asserted during CHECK of op 1 of 4:
  - All outputs 0 the next cycle; no done pulse.
  - A subsequent start with num_ops=1 reproduces the first-op values (A5/66/E7).
